ibex_rf_l2_store: RTL

- Backing (level-2) register store that sits directly downstream of the L1 register cache.
- Accepts up to two read misses (operand ports A and B) and one write-back per request cycle.
- Serializes them onto a single-ported internal array of NumWords x DataWidth flops.
- Returns read data with per-port valid pulses and drives busy_o, which the register file folds into its stall.

---
 rtl/ibex_rf_l2_store_if.sv | 40 ++++
 rtl/ibex_rf_l2_store.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ibex_rf_l2_store_if.sv
// Request/response bundle between the L1 register cache and the L2 backing
// store. Signal names keep the store's point of view (_i into the store,
// _o out of it).
//   rd_a_* / rd_b_* : operand read request (req/addr) and result (valid/data)
//   wr_*            : write-back request (req/addr/data)
//   busy_o          : store occupied, requests ignored while high
//   access_cnt_o    : saturating count of executed array slots
// Modports: slave = the store, master = the requester.
interface ibex_rf_l2_store_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
);
  logic                 rd_a_req_i;
  logic [AddrWidth-1:0] rd_a_addr_i;
  logic                 rd_a_valid_o;
  logic [DataWidth-1:0] rd_a_data_o;
  logic                 rd_b_req_i;
  logic [AddrWidth-1:0] rd_b_addr_i;
  logic                 rd_b_valid_o;
  logic [DataWidth-1:0] rd_b_data_o;
  logic                 wr_req_i;
  logic [AddrWidth-1:0] wr_addr_i;
  logic [DataWidth-1:0] wr_data_i;
  logic                 busy_o;
  logic [31:0]          access_cnt_o;

  modport slave (
    input  rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
           wr_req_i, wr_addr_i, wr_data_i,
    output rd_a_valid_o, rd_a_data_o, rd_b_valid_o, rd_b_data_o,
           busy_o, access_cnt_o
  );

  modport master (
    output rd_a_req_i, rd_a_addr_i, rd_b_req_i, rd_b_addr_i,
           wr_req_i, wr_addr_i, wr_data_i,
    input  rd_a_valid_o, rd_a_data_o, rd_b_valid_o, rd_b_data_o,
           busy_o, access_cnt_o
  );
endinterface

// File: rtl/ibex_rf_l2_store.sv
// L2 backing register store. Captures up to one write-back and two operand
// reads while idle, then executes them one per cycle on a single-ported
// flop array in the fixed order WR, RD_A, RD_B.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset (clears array and all outputs)
//   bus    : ibex_rf_l2_store_if.slave request/response bundle
module ibex_rf_l2_store #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumWords  = 32,
  parameter int unsigned AddrWidth = 5
) (
  input logic               clk_i,
  input logic               rst_ni,
  ibex_rf_l2_store_if.slave bus
);
  localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;

  typedef enum logic [1:0] {IDLE, WR, RD_A, RD_B} state_e;

  state_e               state_q, state_d;
  logic                 busy_q;
  logic                 rda_pend_q, rdb_pend_q, dup_q;
  logic [AddrWidth-1:0] wr_addr_q, rda_addr_q, rdb_addr_q;
  logic [DataWidth-1:0] wr_data_q;
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [1:0]                 vld_q;
  logic [1:0][DataWidth-1:0]  rdata_q;
  logic [31:0]          cnt_q;

  logic                 dup_req, rdb_req_eff, wr_ok;
  logic [AddrWidth-1:0] rd_addr;
  logic [DataWidth-1:0] rd_word;

  function automatic logic in_range(logic [AddrWidth-1:0] a);
    return (32'(a) < NumWords);
  endfunction

  function automatic state_e first_slot(logic w, logic a, logic b);
    if (w) return WR;
    if (a) return RD_A;
    if (b) return RD_B;
    return IDLE;
  endfunction

  // Same-address operand reads collapse into the RD_A slot; B is served from it.
  assign dup_req     = bus.rd_a_req_i & bus.rd_b_req_i &
                       (bus.rd_a_addr_i == bus.rd_b_addr_i);
  assign rdb_req_eff = bus.rd_b_req_i & ~dup_req;

  // x0 and out-of-range writes still burn their slot but touch nothing.
  assign wr_ok = (wr_addr_q != '0) && in_range(wr_addr_q);

  always_comb begin
    rd_addr = (state_q == RD_B) ? rdb_addr_q : rda_addr_q;
    rd_word = '0;
    if (rd_addr != '0 && in_range(rd_addr)) rd_word = mem_q[rd_addr[IdxW-1:0]];
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = first_slot(bus.wr_req_i, bus.rd_a_req_i, rdb_req_eff);
      WR:      state_d = first_slot(1'b0, rda_pend_q, rdb_pend_q);
      RD_A:    state_d = first_slot(1'b0, 1'b0, rdb_pend_q);
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      rda_pend_q <= 1'b0;
      rdb_pend_q <= 1'b0;
      dup_q      <= 1'b0;
      wr_addr_q  <= '0;
      rda_addr_q <= '0;
      rdb_addr_q <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
      vld_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      vld_q   <= '0;
      if (state_q != IDLE && cnt_q != '1) cnt_q <= cnt_q + 32'd1;
      case (state_q)
        IDLE: begin
          // Pending flags are only consulted by later slots of this sequence,
          // so recapturing every idle cycle is harmless.
          rda_pend_q <= bus.rd_a_req_i;
          rdb_pend_q <= rdb_req_eff;
          dup_q      <= dup_req;
          wr_addr_q  <= bus.wr_addr_i;
          rda_addr_q <= bus.rd_a_addr_i;
          rdb_addr_q <= bus.rd_b_addr_i;
          wr_data_q  <= bus.wr_data_i;
        end
        WR: if (wr_ok) mem_q[wr_addr_q[IdxW-1:0]] <= wr_data_q;
        RD_A: begin
          rdata_q[0] <= rd_word;
          vld_q[0]   <= 1'b1;
          if (dup_q) begin
            rdata_q[1] <= rd_word;
            vld_q[1]   <= 1'b1;
          end
        end
        RD_B: begin
          rdata_q[1] <= rd_word;
          vld_q[1]   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.rd_a_valid_o = vld_q[0];
  assign bus.rd_b_valid_o = vld_q[1];
  assign bus.rd_a_data_o  = rdata_q[0];
  assign bus.rd_b_data_o  = rdata_q[1];
  assign bus.access_cnt_o = cnt_q;
endmodule
